mult_div_unit: RTL

- Iterative signed 32x32 multiplier and 32/32 divider for the multicycle MIPS core.
- Sits beside the control FSM. It consumes Start_mult_div and the A/B register values, and produces mult_done/div_done plus the HI/LO results.
- The FSM holds start high through its wait state. On the done pulse, the FSM writes HI/LO in the same cycle, then returns to fetch.

---
 rtl/mult_div_pkg.sv | 21 ++
 rtl/mult_div_unit_if.sv | 41 ++++
 rtl/mult_div_sign_fix.sv | 37 +++
 rtl/mult_div_unit.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/mult_div_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// No ports. Provides the FSM state type, op encodings, default widths and
// the divide-by-zero quotient value.
package mult_div_pkg;

  localparam int unsigned WIDTH_DEF = 32;
  localparam int unsigned ITER_DEF  = 32;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE,
    S_HOLD
  } state_t;

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the control FSM and mult_div_unit.
// master : control FSM side (drives start/op/a/b[/op_unsigned])
// slave  : mult_div_unit side (drives done pulses, busy, hi, lo)
// Optional macro MULT_DIV_UNSIGNED_EN adds op_unsigned (multu/divu select).
interface mult_div_unit_if
  import mult_div_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
);

  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef MULT_DIV_UNSIGNED_EN
  logic             op_unsigned;
`endif
  logic             mult_done;
  logic             div_done;
  logic             div_zero;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b,
`ifdef MULT_DIV_UNSIGNED_EN
    output op_unsigned,
`endif
    input  mult_done, div_done, div_zero, busy, hi, lo
  );

  modport slave (
    input  start, op, a, b,
`ifdef MULT_DIV_UNSIGNED_EN
    input  op_unsigned,
`endif
    output mult_done, div_done, div_zero, busy, hi, lo
  );

endinterface

// File: rtl/mult_div_sign_fix.sv
// Combinational sign correction of magnitude results, shared by mult and div.
// Inputs : op (0 mult / 1 div), a_neg / b_neg operand sign flags (already
//          cleared for unsigned ops), raw_hi/raw_lo magnitude result
//          (mult: product halves; div: remainder / quotient).
// Outputs: hi, lo final signed results.
module mult_div_sign_fix
  import mult_div_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             op,
  input  logic             a_neg,
  input  logic             b_neg,
  input  logic [WIDTH-1:0] raw_hi,
  input  logic [WIDTH-1:0] raw_lo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic [2*WIDTH-1:0] prod;
  logic               res_neg;

  always_comb begin
    res_neg = a_neg ^ b_neg;
    prod    = {raw_hi, raw_lo};
    if (op == OP_MULT) begin
      if (res_neg) prod = -prod;
      hi = prod[2*WIDTH-1:WIDTH];
      lo = prod[WIDTH-1:0];
    end else begin
      // quotient follows the sign rule, remainder follows the dividend
      lo = res_neg ? -raw_lo : raw_lo;
      hi = a_neg   ? -raw_hi : raw_hi;
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed 32x32 multiplier / 32/32 restoring divider.
// Ports: clk, reset (async, active low), bus (mult_div_unit_if.slave):
//   start/op/a/b sampled in IDLE; mult_done/div_done/div_zero one-cycle
//   pulses in DONE; busy high in BUSY; hi/lo hold the last result.
// Optional macro MULT_DIV_UNSIGNED_EN: op_unsigned selects multu/divu.
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned ITER  = ITER_DEF
) (
  input  logic           clk,
  input  logic           reset,
  mult_div_unit_if.slave bus
);

  localparam int unsigned CW = $clog2(ITER);

  state_t             state;
  logic               op_q;
  logic               a_neg_q;
  logic               b_neg_q;
  logic               dz_q;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  logic               signed_op;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   diff;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

`ifdef MULT_DIV_UNSIGNED_EN
  assign signed_op = ~bus.op_unsigned;
`else
  assign signed_op = 1'b1;
`endif

  // Unsigned ops clear the sign flags, so sign_fix passes magnitudes through.
  always_comb begin
    a_neg = signed_op & bus.a[WIDTH-1];
    b_neg = signed_op & bus.b[WIDTH-1];
    a_mag = a_neg ? -bus.a : bus.a;
    b_mag = b_neg ? -bus.b : bus.b;
  end

  // acc holds {partial product, multiplier} for mult and
  // {remainder, dividend/quotient} for div; opnd is multiplicand or divisor.
  always_comb begin
    sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    trial = acc[2*WIDTH-1:WIDTH-1];
    // true difference is < 2^WIDTH whenever it is used, so WIDTH bits suffice
    diff  = trial[WIDTH-1:0] - opnd;
    if (op_q == OP_MULT)
      acc_next = {sum, acc[WIDTH-1:1]};
    else if (trial >= {1'b0, opnd})
      acc_next = {diff, acc[WIDTH-2:0], 1'b1};
    else
      acc_next = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
  end

  mult_div_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .op     (op_q),
    .a_neg  (a_neg_q),
    .b_neg  (b_neg_q),
    .raw_hi (acc_next[2*WIDTH-1:WIDTH]),
    .raw_lo (acc_next[WIDTH-1:0]),
    .hi     (fix_hi),
    .lo     (fix_lo)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      op_q    <= OP_MULT;
      a_neg_q <= 1'b0;
      b_neg_q <= 1'b0;
      dz_q    <= 1'b0;
      count   <= '0;
      acc     <= '0;
      opnd    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            op_q    <= bus.op;
            a_neg_q <= a_neg;
            b_neg_q <= b_neg;
            count   <= '0;
            if (bus.op == OP_DIV && bus.b == '0) begin
              dz_q  <= 1'b1;
              hi_q  <= bus.a;
              lo_q  <= WIDTH'(DIV0_LO);
              state <= S_DONE;
            end else begin
              dz_q  <= 1'b0;
              state <= S_BUSY;
              if (bus.op == OP_MULT) begin
                acc  <= {{WIDTH{1'b0}}, b_mag};
                opnd <= a_mag;
              end else begin
                acc  <= {{WIDTH{1'b0}}, a_mag};
                opnd <= b_mag;
              end
            end
          end
        end
        S_BUSY: begin
          if (!bus.start) begin
            state <= S_IDLE;
          end else begin
            acc   <= acc_next;
            count <= count + CW'(1);
            if (count == CW'(ITER - 1)) begin
              hi_q  <= fix_hi;
              lo_q  <= fix_lo;
              state <= S_DONE;
            end
          end
        end
        S_DONE:  state <= bus.start ? S_HOLD : S_IDLE;
        S_HOLD:  if (!bus.start) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.mult_done = (state == S_DONE) && (op_q == OP_MULT);
  assign bus.div_done  = (state == S_DONE) && (op_q == OP_DIV);
  assign bus.div_zero  = (state == S_DONE) && (op_q == OP_DIV) && dz_q;
  assign bus.busy      = (state == S_BUSY);
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;

endmodule
